// File: rtl/local_mem_banks_pipe.sv
// Banked shared local memory: one independent single-port RAM per bank with a
// fixed-latency response pipeline and a shared zero-init sequencer.

module single_port_mem_wrapper #(
   parameter int DATAW   = 32,
   parameter int SIZE    = 64,
   parameter int BYTEENW = 4,
   localparam int AW     = $clog2(SIZE),
   localparam int LANE   = DATAW / BYTEENW
) (
   input  logic               clk,
   input  logic [AW-1:0]      addr,
   input  logic [BYTEENW-1:0] wren,
   input  logic [DATAW-1:0]   wdata,
   output logic [DATAW-1:0]   rdata
);
   logic [DATAW-1:0] mem_array [SIZE];
   logic [DATAW-1:0] rdata_reg;

   // Read-first RAM with a registered output, so it maps onto block RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTEENW; i++) begin
         if (wren[i]) begin
            mem_array[addr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
         end
      end
      rdata_reg <= mem_array[addr];
   end

   assign rdata = rdata_reg;
endmodule

module local_mem_banks_pipe #(
   parameter int SIZE_BYTE     = 1024,
   parameter int NUM_BANKS     = 4,
   parameter int WORD_BIT      = 32,
   parameter int RD_LATENCY    = 1,
   parameter int INIT_ON_RESET = 1,
   parameter int ADDR_BIT      = 32,
   localparam int WORD_BYTE      = WORD_BIT / 8,
   localparam int BANK_NUM_WORDS = SIZE_BYTE / NUM_BANKS / WORD_BYTE,
   localparam int BANK_ADDR      = $clog2(BANK_NUM_WORDS),
   localparam int WORD_ADDR      = $clog2(WORD_BYTE)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NUM_BANKS-1:0]                 mem_req,
   output logic [NUM_BANKS-1:0]                 mem_gnt,
   input  logic [NUM_BANKS-1:0][ADDR_BIT-1:0]   mem_addr,
   input  logic [NUM_BANKS-1:0]                 mem_we,
   input  logic [NUM_BANKS-1:0][WORD_BYTE-1:0]  mem_be,
   input  logic [NUM_BANKS-1:0][WORD_BIT-1:0]   mem_wdata,
   output logic [NUM_BANKS-1:0]                 mem_rvalid,
   output logic [NUM_BANKS-1:0][WORD_BIT-1:0]   mem_rdata,
   input  logic                                 init_i,
   output logic                                 init_busy_o
);
   typedef enum logic {IDLE, CLEAR} init_state_t;

   localparam logic [BANK_ADDR-1:0] LAST_WORD = BANK_ADDR'(BANK_NUM_WORDS - 1);

   init_state_t          state_reg, state_next;
   logic [BANK_ADDR-1:0] cnt_reg, cnt_next;
   logic                 grant_block;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (init_i) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         CLEAR: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_WORD) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign init_busy_o = (state_reg == CLEAR);
   // The init pulse cycle itself must not grant, since CLEAR starts next edge.
   assign grant_block = (state_reg == CLEAR) || init_i;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic                  gnt;
         logic [BANK_ADDR-1:0]  mac_addr;
         logic [WORD_BYTE-1:0]  mac_wren;
         logic [WORD_BIT-1:0]   mac_wdata;
         logic [WORD_BIT-1:0]   mac_rdata;
         logic [RD_LATENCY-1:0] vld_reg;
         logic                  unused_addr;

         // Bits outside the word index are deliberately ignored (address wrap).
         assign unused_addr = ^mem_addr[gi];

         assign gnt         = mem_req[gi] & rst_ni & ~grant_block;
         assign mem_gnt[gi] = gnt;

         always_comb begin
            mac_addr  = '0;
            mac_wren  = '0;
            mac_wdata = '0;
            if (state_reg == CLEAR) begin
               mac_addr = cnt_reg;
               mac_wren = '1;
            end else if (gnt) begin
               mac_addr  = mem_addr[gi][WORD_ADDR +: BANK_ADDR];
               mac_wren  = mem_be[gi] & {WORD_BYTE{mem_we[gi]}};
               mac_wdata = mem_wdata[gi];
            end
         end

         single_port_mem_wrapper #(
            .DATAW  (WORD_BIT),
            .SIZE   (BANK_NUM_WORDS),
            .BYTEENW(WORD_BYTE)
         ) u_mem (
            .clk  (clk_i),
            .addr (mac_addr),
            .wren (mac_wren),
            .wdata(mac_wdata),
            .rdata(mac_rdata)
         );

         if (RD_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk_i) begin
               if (!rst_ni) vld_reg <= '0;
               else         vld_reg <= gnt;
            end
            assign mem_rdata[gi] = mac_rdata;
         end else begin : g_lat2
            logic [WORD_BIT-1:0] rdata_reg;
            always_ff @(posedge clk_i) begin
               if (!rst_ni) vld_reg <= '0;
               else         vld_reg <= {vld_reg[RD_LATENCY-2:0], gnt};
            end
            always_ff @(posedge clk_i) begin
               rdata_reg <= mac_rdata;
            end
            assign mem_rdata[gi] = rdata_reg;
         end

         assign mem_rvalid[gi] = vld_reg[RD_LATENCY-1];
      end
   endgenerate
endmodule

// File: tb/tb_local_mem_banks_pipe.sv
// Directed bench for local_mem_banks_pipe: two instances (read latency 1 with
// init on reset, read latency 2 without), responses checked from a scoreboard.

module tb_local_mem_banks_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n1, rst_n2, init1, init2;
   logic [3:0]       req1, gnt1, we1, rvalid1, req2, gnt2, we2, rvalid2;
   logic [3:0][31:0] addr1, wdata1, rdata1, addr2, wdata2, rdata2;
   logic [3:0][3:0]  be1, be2;
   logic             busy1, busy2;

   local_mem_banks_pipe #(.RD_LATENCY(1), .INIT_ON_RESET(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n1), .mem_req(req1), .mem_gnt(gnt1), .mem_addr(addr1),
      .mem_we(we1), .mem_be(be1), .mem_wdata(wdata1), .mem_rvalid(rvalid1),
      .mem_rdata(rdata1), .init_i(init1), .init_busy_o(busy1));

   local_mem_banks_pipe #(.RD_LATENCY(2), .INIT_ON_RESET(0)) dut2 (
      .clk_i(clk), .rst_ni(rst_n2), .mem_req(req2), .mem_gnt(gnt2), .mem_addr(addr2),
      .mem_we(we2), .mem_be(be2), .mem_wdata(wdata2), .mem_rvalid(rvalid2),
      .mem_rdata(rdata2), .init_i(init2), .init_busy_o(busy2));

   typedef struct {
      int          dut;
      int          bank;
      bit          is_read;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response monitor: match each rvalid to the oldest outstanding entry of that dut/bank.
   int   mon_idx;
   logic mon_rv;
   logic [31:0] mon_rd;
   exp_t mon_e;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 4; b++) begin
            mon_rv = (d == 0) ? rvalid1[b] : rvalid2[b];
            mon_rd = (d == 0) ? rdata1[b] : rdata2[b];
            if (mon_rv === 1'b1) begin
               mon_idx = -1;
               for (int i = 0; i < sbq.size(); i++) begin
                  if (sbq[i].dut == d && sbq[i].bank == b) begin
                     mon_idx = i;
                     break;
                  end
               end
               if (mon_idx < 0) begin
                  check($sformatf("d%0d_b%0d_unexpected_rvalid", d, b), mon_rv, 1'b0);
               end else begin
                  mon_e = sbq[mon_idx];
                  sbq.delete(mon_idx);
                  check($sformatf("d%0d_b%0d_rsp_cycle", d, b), cyc, mon_e.due);
                  if (mon_e.is_read)
                     check($sformatf("d%0d_b%0d_rdata", d, b), mon_rd, mon_e.data);
                  $display("[TB] dut%0d bank%0d rsp cycle=%0d %s data=%h", d, b, cyc,
                           mon_e.is_read ? "read" : "write", mon_rd);
               end
            end
         end
      end
   end

   task automatic issue(input int d, input int b, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic exp_gnt, input logic [31:0] exp_rdata, input string tag);
      exp_t e;
      @(posedge clk); #1;
      if (d == 0) begin
         req1 = '0; req1[b] = 1'b1; we1[b] = we; addr1[b] = addr; be1[b] = be; wdata1[b] = wdata;
      end else begin
         req2 = '0; req2[b] = 1'b1; we2[b] = we; addr2[b] = addr; be2[b] = be; wdata2[b] = wdata;
      end
      @(negedge clk);
      check({tag, "_gnt"}, (d == 0) ? gnt1[b] : gnt2[b], exp_gnt);
      if (exp_gnt) begin
         e.dut = d; e.bank = b; e.is_read = !we; e.data = exp_rdata;
         e.due = cyc + ((d == 0) ? 1 : 2);
         sbq.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req1 = '0;
      req2 = '0;
   endtask

   int   busy_cnt;
   bit   done;
   logic gnt_seen;
   logic rv_seen;

   initial begin
      rst_n1 = 1'b0; rst_n2 = 1'b0; init1 = 1'b0; init2 = 1'b0;
      req1 = '1; req2 = '1; we1 = '0; we2 = '0; addr1 = '0; addr2 = '0;
      be1 = '0; be2 = '0; wdata1 = '0; wdata2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy1", busy1, 1'b1);
      check("reset_busy2", busy2, 1'b0);
      check("reset_gnt1", gnt1, 4'h0);
      check("reset_gnt2", gnt2, 4'h0);
      check("reset_rvalid1", rvalid1, 4'h0);
      check("reset_rvalid2", rvalid2, 4'h0);

      // Release reset: dut1 clears for 64 cycles while all banks keep requesting.
      @(posedge clk); #1;
      rst_n1 = 1'b1; rst_n2 = 1'b1; req2 = '0;
      busy_cnt = 0; done = 0; gnt_seen = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (busy1) begin
            busy_cnt++;
            gnt_seen |= |gnt1;
         end else done = 1;
      end
      check("init_busy_cycles", busy_cnt, 64);
      check("gnt_during_init", gnt_seen, 1'b0);
      check("first_gnt_after_init", gnt1, 4'hF);
      check("busy2_no_auto_init", busy2, 1'b0);
      req1 = '0;

      for (int b = 0; b < 4; b++) begin
         issue(0, b, 1'b0, 32'h0,  4'h0, 32'h0, 1'b1, 32'h0, $sformatf("zero_rd0_b%0d", b));
         issue(0, b, 1'b0, 32'hFC, 4'h0, 32'h0, 1'b1, 32'h0, $sformatf("zero_rdfc_b%0d", b));
      end
      idle();

      issue(0, 2, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, "raw_wr");
      issue(0, 2, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, "raw_rd");
      idle();

      issue(0, 3, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1, 32'h0, "be_wr_full");
      issue(0, 3, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 1'b1, 32'h0, "be_wr_part");
      issue(0, 3, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 32'h11BB33DD, "be_rd");
      idle();

      issue(0, 1, 1'b1, 32'h8,   4'hF, 32'h12345678, 1'b1, 32'h0, "iso_wr_b1");
      issue(0, 0, 1'b1, 32'h8,   4'hF, 32'h87654321, 1'b1, 32'h0, "iso_wr_b0");
      issue(0, 0, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, "wrap_wr");
      issue(0, 0, 1'b0, 32'h0,   4'h0, 32'h0, 1'b1, 32'hCAFEF00D, "wrap_rd");
      issue(0, 1, 1'b0, 32'h8,   4'h0, 32'h0, 1'b1, 32'h12345678, "iso_rd_b1");
      issue(0, 1, 1'b0, 32'h0,   4'h0, 32'h0, 1'b1, 32'h0, "iso_rd0_b1");
      issue(0, 0, 1'b0, 32'h8,   4'h0, 32'h0, 1'b1, 32'h87654321, "iso_rd_b0");
      idle();

      // Latency-2 instance: preload then four back-to-back reads.
      for (int i = 0; i < 4; i++)
         issue(1, 0, 1'b1, 32'(i * 4), 4'hF, 32'(i + 1), 1'b1, 32'h0, $sformatf("l2_wr%0d", i));
      for (int i = 0; i < 4; i++)
         issue(1, 0, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b1, 32'(i + 1), $sformatf("l2_rd%0d", i));
      idle();

      // Init pulse right after a granted read on bank 1.
      issue(0, 1, 1'b1, 32'h40, 4'hF, 32'hA5A5A5A5, 1'b1, 32'h0, "pre_init_wr");
      issue(0, 1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hA5A5A5A5, "pre_init_rd");
      @(posedge clk); #1;
      init1 = 1'b1;
      @(negedge clk);
      check("init_cycle_gnt", gnt1[1], 1'b0);
      @(posedge clk); #1;
      init1 = 1'b0; req1 = '0;
      busy_cnt = 0; done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (busy1) busy_cnt++;
         else done = 1;
         init1 = (busy_cnt == 10 && !done);
      end
      init1 = 1'b0;
      check("reinit_busy_cycles", busy_cnt, 64);
      issue(0, 1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'h0, "post_init_rd_b1");
      issue(0, 0, 1'b0, 32'h8,  4'h0, 32'h0, 1'b1, 32'h0, "post_init_rd_b0");
      issue(0, 3, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 32'h0, "post_init_rd_b3");
      idle();

      // Reset the latency-2 instance while a read is in flight: response is dropped.
      @(posedge clk); #1;
      req2 = '0; req2[0] = 1'b1; we2[0] = 1'b0; addr2[0] = 32'h4;
      @(negedge clk);
      check("drop_rd_gnt", gnt2[0], 1'b1);
      @(posedge clk); #1;
      req2 = '0; rst_n2 = 1'b0;
      rv_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         rv_seen |= |rvalid2;
      end
      check("reset_drops_rvalid", rv_seen, 1'b0);
      check("reset2_busy", busy2, 1'b0);
      @(posedge clk); #1;
      rst_n2 = 1'b1;

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
